// File: rtl/snpu_entropy_pool.sv
// snpu_entropy_pool: synchronised oscillator fold, repetition health test, optional von Neumann
// debiaser (SNPU_VN_DEBIAS_EN), word packer and first-word-fall-through output FIFO.
module snpu_entropy_pool #(
    parameter int CHANNELS   = 8,
    parameter int RAW_W      = 16,
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int REP_LIMIT  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS*RAW_W-1:0]     raw_in,
    input  logic [CHANNELS-1:0]           chan_mask,
    input  logic                          freeze,
    output logic [WORD_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow,
    output logic                          health_fail
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int RUN_W = $clog2(REP_LIMIT + 1);
    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [CHANNELS*RAW_W-1:0] sync1, sync2;
    logic [1:0] sync_vld;
    logic fold_bit, fold_vld, fold_next, sample, trip;

    always_comb begin
        fold_next = 1'b0;
        for (int c = 0; c < CHANNELS; c++)
            fold_next = fold_next ^ (chan_mask[c] & (^sync2[c*RAW_W +: RAW_W]));
    end

    // sync_vld keeps pre-reset synchroniser contents from ever reaching the fold consumers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            sync_vld <= '0;
            fold_bit <= 1'b0;
            fold_vld <= 1'b0;
        end else begin
            sync1    <= raw_in;
            sync2    <= sync1;
            sync_vld <= {sync_vld[0], 1'b1};
            if (!freeze) begin
                fold_bit <= fold_next;
                fold_vld <= sync_vld[1];
            end
        end

    assign sample = fold_vld & ~freeze & ~health_fail;

    logic [RUN_W-1:0] run, run_next;
    logic prev_bit;

    assign run_next = (run != '0 && fold_bit == prev_bit) ? run + 1'b1 : RUN_W'(1);
    assign trip     = sample && run_next == RUN_W'(REP_LIMIT);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            run         <= '0;
            prev_bit    <= 1'b0;
            health_fail <= 1'b0;
        end else if (sample) begin
            run      <= run_next;
            prev_bit <= fold_bit;
            if (trip) health_fail <= 1'b1;
        end

    logic emit, emit_bit;

`ifdef SNPU_VN_DEBIAS_EN
    typedef enum logic {IDLE, HAVE_FIRST} pair_t;
    pair_t state, state_next;
    logic first_bit;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else if (trip) state <= IDLE;
        else state <= state_next;

    always_ff @(posedge clk or posedge rst)
        if (rst) first_bit <= 1'b0;
        else if (sample && !trip && state == IDLE) first_bit <= fold_bit;

    always_comb begin
        state_next = state;
        if (sample && !trip) state_next = (state == IDLE) ? HAVE_FIRST : IDLE;
    end

    always_comb begin
        emit     = sample && !trip && state == HAVE_FIRST && fold_bit != first_bit;
        emit_bit = first_bit;
    end
`else
    assign emit     = sample & ~trip;
    assign emit_bit = fold_bit;
`endif

    logic [WORD_W-1:0] acc, word;
    logic [CNT_W-1:0] cnt;
    logic push;

    assign word = {acc[WORD_W-2:0], emit_bit};
    assign push = emit && cnt == CNT_W'(WORD_W - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (trip) begin
            acc <= '0;
            cnt <= '0;
        end else if (emit) begin
            acc <= word;
            cnt <= push ? '0 : cnt + 1'b1;
        end

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic pop, do_push;

    assign out_valid = fill_level != '0 && !health_fail;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign pop       = out_valid & out_ready;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign do_push   = push & (~fill_level[PTR_W] | pop);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            overflow   <= 1'b0;
        end else if (trip) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fill_level <= fill_level + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, pop};
            if (push && !do_push) overflow <= 1'b1;
        end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= word;
endmodule

// File: tb/tb_snpu_entropy_pool.sv
// tb_snpu_entropy_pool: randomized stimulus checked against a queue-based reference model of the pool.
module tb_snpu_entropy_pool;
    localparam int CH = 4, RW = 4, WW = 8, FD = 4, RL = 16;
`ifdef SNPU_VN_DEBIAS_EN
    localparam int EXP_T = 19;
    localparam logic [7:0] EXP_W = 8'hFF;
`else
    localparam int EXP_T = 11;
    localparam logic [7:0] EXP_W = 8'hAA;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic [15:0] raw_in = '0;
    logic [3:0] chan_mask = 4'hF;
    logic freeze = 1'b0, out_ready = 1'b0;
    logic [7:0] out_data;
    logic out_valid, overflow, health_fail;
    logic [2:0] fill_level;

    snpu_entropy_pool #(.CHANNELS(CH), .RAW_W(RW), .WORD_W(WW), .FIFO_DEPTH(FD), .REP_LIMIT(RL)) dut (
        .clk(clk), .rst(rst), .raw_in(raw_in), .chan_mask(chan_mask), .freeze(freeze),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fill_level(fill_level), .overflow(overflow), .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    logic [13:0] dut_outs;
    assign dut_outs = {out_valid, out_data, fill_level, overflow, health_fail};

    // reference model state
    logic [15:0] p1, p2;
    logic v1, v2, mf, mfv, prev, mh, mo;
    int run, pend, mcnt, pushes;
    logic [7:0] macc;
    logic [7:0] mq[$];
    logic [7:0] words[$];
    logic dprev = 1'b0;
    int drun = 0;

    function automatic logic fold(logic [15:0] r, logic [3:0] m);
        logic x;
        x = 1'b0;
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < RW; k++)
                if (m[c]) x = x ^ r[c*RW + k];
        return x;
    endfunction

    function automatic logic [13:0] exp_outs();
        logic v;
        v = mq.size() != 0 && !mh;
        return {v, v ? mq[0] : 8'h00, 3'(mq.size()), mo, mh};
    endfunction

    task automatic model_reset();
        p1 = '0; p2 = '0; v1 = 0; v2 = 0; mf = 0; mfv = 0; prev = 0; mh = 0; mo = 0;
        run = 0; pend = -1; mcnt = 0; pushes = 0; macc = '0;
        mq.delete();
        words.delete();
    endtask

    task automatic model_edge();
        logic pop, e, eb, b;
        pop = mq.size() != 0 && !mh && out_ready;
        e = 0;
        eb = 0;
        if (!freeze && mfv && !mh) begin
            b = mf;
            run = (run > 0 && b == prev) ? run + 1 : 1;
            prev = b;
            if (run == RL) begin
                mh = 1; mq.delete(); macc = '0; mcnt = 0; pend = -1; pop = 0;
            end else begin
`ifdef SNPU_VN_DEBIAS_EN
                if (pend < 0) pend = int'(b);
                else begin
                    if (int'(b) != pend) begin e = 1; eb = pend[0]; end
                    pend = -1;
                end
`else
                e = 1;
                eb = b;
`endif
            end
        end
        if (pop) void'(mq.pop_front());
        if (e) begin
            macc = {macc[6:0], eb};
            mcnt++;
            if (mcnt == WW) begin
                mcnt = 0;
                pushes++;
                words.push_back(macc);
                if (mq.size() < FD) mq.push_back(macc);
                else mo = 1;
            end
        end
        if (!freeze) begin
            mf = fold(p2, chan_mask);
            mfv = v2;
        end
        p2 = p1; v2 = v1; p1 = raw_in; v1 = 1;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // random raw word whose channel-0 parity is a random bit with runs kept short
    task automatic drive_rand();
        logic b;
        logic [15:0] r;
        b = 1'($urandom);
        r = 16'($urandom);
        if (drun >= 4 && b == dprev) b = ~b;
        drun = (b == dprev) ? drun + 1 : 1;
        dprev = b;
        r[0] = r[0] ^ (^r[3:0]) ^ b;
        raw_in = r;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (dut_outs !== 14'h0) begin errors++; $display("FAIL test_reset initial: got %h expected 0", dut_outs); end
        @(negedge clk);
        rst = 1'b0;
        chan_mask = 4'hF;
        out_ready = 1'b0;
        for (int i = 0; i < 60; i++) begin
            raw_in = 16'($urandom);
            tick();
            checks++;
            if (dut_outs !== exp_outs()) begin errors++; $display("FAIL test_reset run %0d: got %h expected %h", i, dut_outs, exp_outs()); end
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_outs !== 14'h0) begin errors++; $display("FAIL test_reset async: got %h expected 0", dut_outs); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            raw_in = 16'($urandom);
            tick();
            checks++;
            if (dut_outs !== exp_outs() || (i < 10 && out_valid !== 1'b0)) begin
                errors++;
                $display("FAIL test_reset refill %0d: got %h expected %h", i, dut_outs, exp_outs());
            end
        end
    endtask

    task automatic test_toggle();
        int n;
        n = 0;
        do_reset();
        chan_mask = 4'h1;
        out_ready = 1'b0;
        for (int i = 0; i < 40 && n == 0; i++) begin
            raw_in = {12'($urandom), 3'b000, 1'(i % 2 == 0)};
            tick();
            checks++;
            if (dut_outs !== exp_outs()) begin errors++; $display("FAIL test_toggle %0d: got %h expected %h", i, dut_outs, exp_outs()); end
            if (out_valid === 1'b1) n = i + 1;
        end
        checks++;
        if (n != EXP_T) begin errors++; $display("FAIL test_toggle latency: got %0d expected %0d", n, EXP_T); end
        checks++;
        if (out_data !== EXP_W) begin errors++; $display("FAIL test_toggle word: got %h expected %h", out_data, EXP_W); end
    endtask

    task automatic test_health();
        do_reset();
        out_ready = 1'($urandom);
        chan_mask = $urandom_range(1) ? 4'h0 : 4'hF;
        for (int i = 0; i < 19; i++) begin
            raw_in = (chan_mask == 4'h0) ? 16'($urandom) : 16'h0;
            tick();
            checks++;
            if (dut_outs !== exp_outs() || health_fail !== 1'(i == 18)) begin
                errors++;
                $display("FAIL test_health trip %0d: got %h expected %h", i, dut_outs, exp_outs());
            end
        end
        checks++;
        if ({out_valid, fill_level} !== 4'h0) begin errors++; $display("FAIL test_health flush: got %h expected 0", {out_valid, fill_level}); end
        chan_mask = 4'h1;
        for (int i = 0; i < 20; i++) begin
            raw_in = {15'h0, 1'(i % 2)};
            out_ready = 1'($urandom);
            tick();
            checks++;
            if (health_fail !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL test_health sticky %0d: got hf=%b valid=%b expected hf=1 valid=0", i, health_fail, out_valid);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        chan_mask = 4'h1;
        out_ready = 1'b0;
        for (int i = 0; i < 1000 && pushes < 5; i++) begin
            drive_rand();
            tick();
            checks++;
            if (dut_outs !== exp_outs()) begin errors++; $display("FAIL test_overflow fill %0d: got %h expected %h", i, dut_outs, exp_outs()); end
        end
        checks++;
        if (pushes != 5) begin errors++; $display("FAIL test_overflow timeout: got %0d words expected 5", pushes); end
        checks++;
        if ({fill_level, overflow} !== {3'd4, 1'b1}) begin
            errors++;
            $display("FAIL test_overflow state: got fill=%0d ovf=%b expected fill=4 ovf=1", fill_level, overflow);
        end
        freeze = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== words[k]) begin
                errors++;
                $display("FAIL test_overflow drain %0d: got %b/%h expected 1/%h", k, out_valid, out_data, words[k]);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL test_overflow fifth: got valid=%b expected 0", out_valid); end
        freeze = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_freeze();
        do_reset();
        chan_mask = 4'h1;
        out_ready = 1'b0;
        for (int i = 0; i < 300 && mcnt < 3; i++) begin
            drive_rand();
            tick();
            checks++;
            if (dut_outs !== exp_outs()) begin errors++; $display("FAIL test_freeze pre %0d: got %h expected %h", i, dut_outs, exp_outs()); end
        end
        freeze = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (dut_outs !== exp_outs() || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL test_freeze hold %0d: got %h expected %h", i, dut_outs, exp_outs());
            end
        end
        freeze = 1'b0;
        for (int i = 0; i < 300 && out_valid !== 1'b1; i++) begin
            drive_rand();
            tick();
            checks++;
            if (dut_outs !== exp_outs()) begin errors++; $display("FAIL test_freeze post %0d: got %h expected %h", i, dut_outs, exp_outs()); end
        end
        checks++;
        if (out_valid !== 1'b1 || words.size() == 0 || out_data !== words[0]) begin
            errors++;
            $display("FAIL test_freeze word: got %b/%h expected 1/%h", out_valid, out_data, words.size() ? words[0] : 8'h00);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        chan_mask = 4'h1;
        for (int i = 0; i < 400; i++) begin
            out_ready = 1'($urandom);
            freeze = ($urandom_range(3) == 0);
            if (!freeze) drive_rand();
            tick();
            checks++;
            if (dut_outs !== exp_outs()) begin errors++; $display("FAIL test_back_to_back %0d: got %h expected %h", i, dut_outs, exp_outs()); end
        end
        freeze = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_toggle();
        test_health();
        test_overflow();
        test_freeze();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/snpu_entropy_pool.md
# snpu_entropy_pool

Parametrised successor to the SNPU free-running random bank. It samples CHANNELS asynchronous oscillator banks through a synchroniser and folds the enabled channels into one raw bit per cycle. A repetition-count health test watches the raw bit, an optional von Neumann debiaser follows it, and the output bits are packed into WORD_W-bit words. Words are buffered in a FIFO and read out over a valid/ready handshake. It sits between the `funky_rnd_n` oscillator banks and the chip I/O mux.

## Interface
- CHANNELS, 8: number of oscillator banks sampled.
- RAW_W, 16: bits per bank.
- WORD_W, 16: output word width, 2..32.
- FIFO_DEPTH, 4: word buffer depth, power of two, >=2.
- REP_LIMIT, 32: run length of identical raw bits that fails health, 2..255.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- raw_in  in  CHANNELS*RAW_W  unsynchronised oscillator outputs; channel c occupies bits [c*RAW_W +: RAW_W].
- chan_mask  in  CHANNELS  1 = channel contributes to the fold.
- freeze  in  1  1 = sampling pipeline paused.
- out_data  out  WORD_W  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head word.
- fill_level  out  $clog2(FIFO_DEPTH)+1  words held.
- overflow  out  1  sticky; a completed word was dropped.
- health_fail  out  1  sticky; repetition test tripped.

## Operation
- Synchroniser: 2 flops on all of raw_in, always clocked; freeze does not gate it.
- Fold register: when freeze=0, it loads the XOR of all bits of all channels with chan_mask=1. When freeze=1 it holds, and all downstream state (pair FSM, health counter, accumulator, bit count) also holds.
- Health test: run counter on the fold output, incremented each sampled cycle.
  - Bit equal to previous: run++.
  - Bit differs: run=1.
  - run reaching REP_LIMIT sets health_fail.
  - Rising edge of health_fail: FIFO flushed, accumulator and bit count cleared, pair FSM to IDLE.
  - While health_fail=1: no bits emitted, no pushes, out_valid=0.
  - health_fail clears only by rst.
- Debiaser pair FSM, states IDLE and HAVE_FIRST:
  - IDLE: latch the bit, go to HAVE_FIRST.
  - HAVE_FIRST: if the bit differs from the latched bit, emit the latched bit; if equal, emit nothing. Return to IDLE either way.
- Accumulator: each emitted bit enters at bit 0 and older bits shift up, so the oldest bit ends in the MSB. When the bit count reaches WORD_W, the word is pushed and the count resets to 0 in the same cycle.
- Push while FIFO full, with no pop that cycle: word discarded, overflow set.
- Push and pop in the same cycle while full: both succeed; fill_level unchanged.
- FIFO is first-word-fall-through. A pop happens when out_valid & out_ready. out_ready while empty is ignored.
- fill_level = pushes minus pops, saturating at FIFO_DEPTH.
- rst, including mid-word: all state cleared immediately. Every output resets to 0: out_data, out_valid, fill_level, overflow, health_fail.

## Timing
- raw_in change to fold register: 3 rising edges (2 sync + fold).
- Fold bit to accumulator: same cycle as emission.
- Completing bit to out_valid=1: push on that edge; out_valid and out_data valid after it. That is one cycle of latency through an empty FIFO.
- Pop takes effect on the clock edge. The next head word, or out_valid=0, appears right after that edge.
- freeze takes effect on the next edge. Words already in the FIFO stay readable while frozen.
- Health trip: health_fail=1 after the edge that samples the REP_LIMIT-th identical bit. The flush takes effect on the same edge.

## Configuration
- SNPU_VN_DEBIAS_EN defined: pair FSM present. Output rate is on average at most 1/4 of raw bits.
- Not defined: FSM removed, and every sampled fold bit is emitted directly to the accumulator. One word per WORD_W sampled cycles.

## Test plan
Parameters for all scenarios: CHANNELS=4, RAW_W=4, WORD_W=8, FIFO_DEPTH=4, REP_LIMIT=16.
- Reset: assert rst mid-word with data in the FIFO -> all outputs 0 without waiting for clk; after release, first word needs 8 fresh bits.
- No debias: chan_mask=0001, channel 0 bit 0 toggling 1,0,1,... each sampled cycle -> out_data=0xAA, with out_valid rising 1 cycle after the 8th bit.
- Debias (SNPU_VN_DEBIAS_EN): same stimulus -> pairs (1,0) each emit 1; out_data=0xFF after 16 raw bits.
- Health: hold all raw_in at 0 with chan_mask=1111, or set chan_mask=0000 -> health_fail=1 after the 16th sampled bit; out_valid=0, fill_level=0; a later toggling input does not clear it.
- Overflow/ordering: out_ready=0 while 5 words are produced -> fill_level=4, overflow=1; then out_ready=1 drains words 1-4 in order and the 5th is absent.
- Freeze: freeze=1 after 3 of 8 bits for 10 cycles -> bit count holds at 3; on release the same word completes after 5 more bits with contents unchanged.
